// File: rtl/coop_packet_tx.sv
// Periodic / on-demand ASCII telemetry packet sender for a UART TX FIFO: "P:dddd:dddd\r\n".
// Defining COOP_TX_CSUM_EN inserts "*HH" (XOR of 'P' through the last digit) before "\r\n".
module coop_packet_tx #(
    parameter int FCLK_HZ        = 100_000_000,
    parameter int SEND_PERIOD_MS = 50,
    parameter int NUM_FIELDS     = 2,
    parameter int VAL_W          = 12,
    parameter int DIGITS         = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_FIELDS*VAL_W-1:0] fields,
    input  logic                        send_now,
    input  logic                        tx_full,
    output logic                        wr_uart,
    output logic [7:0]                  w_data,
    output logic                        busy,
    output logic                        pkt_done
);

    localparam int CYCLES  = (FCLK_HZ / 1000) * SEND_PERIOD_MS;
    localparam int CNT_W   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam int BCD_W   = DIGITS * 4;
    localparam int MAX_VAL = 10 ** DIGITS - 1;
    // Index of the first byte after the last digit.
    localparam int DIG_END = 1 + NUM_FIELDS * (1 + DIGITS);
`ifdef COOP_TX_CSUM_EN
    localparam int PKT_LEN = DIG_END + 5;
`else
    localparam int PKT_LEN = DIG_END + 2;
`endif
    localparam int IDX_W   = $clog2(PKT_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t                        state_reg, state_next;
    logic [CNT_W-1:0]              cnt_reg, cnt_next;
    logic                          tick;
    logic [NUM_FIELDS*VAL_W-1:0]   snap_reg, snap_next;
    logic [IDX_W-1:0]              idx_reg, idx_next;
    logic                          busy_reg, busy_next;
    logic                          wr_reg, wr_next;
    logic                          done_reg, done_next;
    logic [7:0]                    w_data_reg, w_data_next;
    logic [7:0]                    cur_byte;
    logic [NUM_FIELDS*BCD_W-1:0]   digs_all;
`ifdef COOP_TX_CSUM_EN
    logic [7:0]                    csum_reg, csum_next;
`endif

    // Saturating binary-to-BCD (shift-add-3); values above MAX_VAL become all nines.
    function automatic logic [BCD_W-1:0] to_bcd(input logic [VAL_W-1:0] v);
        logic [BCD_W-1:0] bcd;
        bcd = '0;
        if (32'(v) > 32'(MAX_VAL)) begin
            for (int k = 0; k < DIGITS; k++)
                bcd[k*4 +: 4] = 4'd9;
        end else begin
            for (int i = VAL_W - 1; i >= 0; i--) begin
                for (int k = 0; k < DIGITS; k++)
                    if (bcd[k*4 +: 4] >= 4'd5)
                        bcd[k*4 +: 4] = bcd[k*4 +: 4] + 4'd3;
                bcd = {bcd[BCD_W-2:0], v[i]};
            end
        end
        return bcd;
    endfunction

`ifdef COOP_TX_CSUM_EN
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction
`endif

    // Byte at packet position idx, built from the snapshot digits.
    function automatic logic [7:0] byte_of(
        input logic [IDX_W-1:0]            idx,
        input logic [NUM_FIELDS*BCD_W-1:0] digs
`ifdef COOP_TX_CSUM_EN
        , input logic [7:0]                cs
`endif
    );
        logic [7:0] b;
        int         base;
        b = 8'h00;
        if (idx == '0)
            b = 8'h50;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            base = 1 + f * (1 + DIGITS);
            if (idx == IDX_W'(base))
                b = 8'h3A;
            for (int k = 0; k < DIGITS; k++)
                if (idx == IDX_W'(base + 1 + k))
                    b = 8'h30 | {4'h0, digs[f*BCD_W + (DIGITS-1-k)*4 +: 4]};
        end
`ifdef COOP_TX_CSUM_EN
        if (idx == IDX_W'(DIG_END))
            b = 8'h2A;
        if (idx == IDX_W'(DIG_END + 1))
            b = hex_char(cs[7:4]);
        if (idx == IDX_W'(DIG_END + 2))
            b = hex_char(cs[3:0]);
`endif
        if (idx == IDX_W'(PKT_LEN - 2))
            b = 8'h0D;
        if (idx == IDX_W'(PKT_LEN - 1))
            b = 8'h0A;
        return b;
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_bcd
            assign digs_all[gi*BCD_W +: BCD_W] = to_bcd(snap_reg[gi*VAL_W +: VAL_W]);
        end
    endgenerate

    always_comb begin
        tick     = (cnt_reg == CNT_W'(CYCLES - 1));
        cnt_next = tick ? '0 : cnt_reg + 1'b1;
    end

    always_comb begin
        state_next = state_reg;
        snap_next  = snap_reg;
        idx_next   = idx_reg;
        busy_next  = busy_reg;
        wr_next    = 1'b0;
        done_next  = 1'b0;
`ifdef COOP_TX_CSUM_EN
        csum_next  = csum_reg;
        cur_byte   = byte_of(idx_reg, digs_all, csum_reg);
`else
        cur_byte   = byte_of(idx_reg, digs_all);
`endif

        case (state_reg)
            S_IDLE: begin
                if (tick || send_now) begin
                    snap_next  = fields;
                    idx_next   = '0;
                    busy_next  = 1'b1;
                    state_next = S_SEND;
`ifdef COOP_TX_CSUM_EN
                    csum_next  = 8'h00;
`endif
                end
            end
            S_SEND: begin
                if (!tx_full) begin
                    wr_next    = 1'b1;
                    state_next = S_GAP;
`ifdef COOP_TX_CSUM_EN
                    // Only committed bytes up to the last digit enter the checksum.
                    if (idx_reg < IDX_W'(DIG_END))
                        csum_next = csum_reg ^ cur_byte;
`endif
                end
            end
            S_GAP: begin
                if (idx_reg == IDX_W'(PKT_LEN - 1)) begin
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    idx_next   = idx_reg + 1'b1;
                    state_next = S_SEND;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Load the upcoming byte so w_data is already valid throughout S_SEND.
        w_data_next = w_data_reg;
        if (state_next == S_SEND) begin
`ifdef COOP_TX_CSUM_EN
            w_data_next = byte_of(idx_next, digs_all, csum_next);
`else
            w_data_next = byte_of(idx_next, digs_all);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            snap_reg   <= '0;
            idx_reg    <= '0;
            busy_reg   <= 1'b0;
            wr_reg     <= 1'b0;
            done_reg   <= 1'b0;
            w_data_reg <= 8'h00;
`ifdef COOP_TX_CSUM_EN
            csum_reg   <= 8'h00;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            snap_reg   <= snap_next;
            idx_reg    <= idx_next;
            busy_reg   <= busy_next;
            wr_reg     <= wr_next;
            done_reg   <= done_next;
            w_data_reg <= w_data_next;
`ifdef COOP_TX_CSUM_EN
            csum_reg   <= csum_next;
`endif
        end
    end

    assign wr_uart  = wr_reg;
    assign w_data   = w_data_reg;
    assign busy     = busy_reg;
    assign pkt_done = done_reg;

endmodule

// File: tb/tb_coop_packet_tx.sv
// Directed bench for coop_packet_tx: main instance (no ticks), fast-tick instance and a
// single-field saturation instance; all bytes written are captured by negedge monitors.
module tb_coop_packet_tx;

`ifdef COOP_TX_CSUM_EN
    localparam int LEN2 = 16;
`else
    localparam int LEN2 = 13;
`endif
    localparam int TPER = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [23:0] fields_a, fields_t;
    logic [15:0] fields_s;
    logic        send_a, send_t, send_s, full_a, full_t, full_s;
    logic        wr_a, wr_t, wr_s, busy_a, busy_t, busy_s, done_a, done_t, done_s;
    logic [7:0]  wd_a, wd_t, wd_s;

    coop_packet_tx dut_a (
        .clk(clk), .rst(rst), .fields(fields_a), .send_now(send_a), .tx_full(full_a),
        .wr_uart(wr_a), .w_data(wd_a), .busy(busy_a), .pkt_done(done_a));

    coop_packet_tx #(.FCLK_HZ(TPER * 1000), .SEND_PERIOD_MS(1)) dut_t (
        .clk(clk), .rst(rst), .fields(fields_t), .send_now(send_t), .tx_full(full_t),
        .wr_uart(wr_t), .w_data(wd_t), .busy(busy_t), .pkt_done(done_t));

    coop_packet_tx #(.NUM_FIELDS(1), .VAL_W(16)) dut_s (
        .clk(clk), .rst(rst), .fields(fields_s), .send_now(send_s), .tx_full(full_s),
        .wr_uart(wr_s), .w_data(wd_s), .busy(busy_s), .pkt_done(done_s));

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [7:0] qa[$], qt[$], qs[$];
    int ta[$];
    int dca = 0, dct = 0, dcs = 0, dcyc_a = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wr_a) begin qa.push_back(wd_a); ta.push_back(cyc); end
        if (wr_t) qt.push_back(wd_t);
        if (wr_s) qs.push_back(wd_s);
        if (done_a) begin dca++; dcyc_a = cyc; end
        if (done_t) dct++;
        if (done_s) dcs++;
    end

    // Advance one cycle; inputs are driven and outputs read just after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic string with_trailer(string body);
        string s;
        s = body;
`ifdef COOP_TX_CSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 0; i < body.len(); i++) x ^= body[i];
            s = {s, $sformatf("*%02X", x)};
        end
`endif
        return {s, "\r\n"};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        fields_a = '0; fields_t = '0; fields_s = '0;
        send_a = 0; send_t = 0; send_s = 0; full_a = 0; full_t = 0; full_s = 0;
        repeat (3) step();
        n_assert++; if (wr_a !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b expected 0", wr_a); end
        n_assert++; if (wd_a !== 8'h00) begin n_fail++; $display("FAIL reset_wdata: got %02h expected 00", wd_a); end
        n_assert++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        n_assert++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_a); end
        n_assert++; if (busy_t !== 1'b0) begin n_fail++; $display("FAIL reset_busy_t: got %b expected 0", busy_t); end
        $display("[reset] outputs checked during reset");
    endtask

    task automatic test_first_tick();
        string exp;
        int n;
        fields_t = {12'd2000, 12'd7};
        exp = with_trailer("P:0007:2000");
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            n++;
            if (busy_t) break;
        end
        n_assert++; if (n != TPER) begin n_fail++; $display("FAIL first_tick: busy after %0d clocks, expected %0d", n, TPER); end
        for (int i = 0; i < 100; i++) begin step(); if (dct != 0) break; end
        n_assert++; if (qt.size() != exp.len()) begin n_fail++; $display("FAIL tick_len: got %0d expected %0d", qt.size(), exp.len()); end
        for (int i = 0; i < exp.len() && i < qt.size(); i++) begin
            logic [7:0] e;
            e = exp[i];
            n_assert++; if (qt[i] !== e) begin n_fail++; $display("FAIL tick_byte%0d: got %02h expected %02h", i, qt[i], e); end
        end
        $display("[first_tick] packet of %0d bytes after %0d clocks", qt.size(), n);
    endtask

    task automatic test_basic();
        string exp;
        int d0, s_cyc, bad;
`ifdef COOP_TX_CSUM_EN
        exp = "P:0123:4095*58\r\n";
`else
        exp = "P:0123:4095\r\n";
`endif
        d0 = dca;
        qa.delete(); ta.delete();
        fields_a = {12'd4095, 12'd123};
        send_a = 1'b1; s_cyc = cyc;
        step();
        send_a = 1'b0;
        n_assert++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy_a); end
        for (int i = 0; i < 200; i++) begin step(); if (dca != d0) break; end
        n_assert++; if (dca != d0 + 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected %0d", dca - d0, 1); end
        n_assert++; if (qa.size() != exp.len()) begin n_fail++; $display("FAIL basic_len: got %0d expected %0d", qa.size(), exp.len()); end
        for (int i = 0; i < exp.len() && i < qa.size(); i++) begin
            logic [7:0] e;
            e = exp[i];
            n_assert++; if (qa[i] !== e) begin n_fail++; $display("FAIL basic_byte%0d: got %02h expected %02h", i, qa[i], e); end
        end
        if (ta.size() > 0) begin
            n_assert++; if (ta[0] != s_cyc + 2) begin n_fail++; $display("FAIL basic_first_write: cycle %0d expected %0d", ta[0], s_cyc + 2); end
            bad = 0;
            for (int i = 1; i < ta.size(); i++) if (ta[i] - ta[i-1] != 2) bad++;
            n_assert++; if (bad != 0) begin n_fail++; $display("FAIL basic_spacing: %0d gaps not 2 cycles, expected 0", bad); end
            n_assert++; if (dcyc_a != ta[ta.size()-1] + 1) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected %0d", dcyc_a, ta[ta.size()-1] + 1); end
        end
        n_assert++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", busy_a); end
        $display("[basic] packet of %0d bytes", qa.size());
    endtask

    task automatic test_busy_send_ignored();
        int d0;
        d0 = dca;
        qa.delete(); ta.delete();
        send_a = 1'b1; step(); send_a = 1'b0;
        repeat (6) step();
        send_a = 1'b1; step(); send_a = 1'b0;
        for (int i = 0; i < 200; i++) begin step(); if (dca != d0) break; end
        repeat (30) step();
        n_assert++; if (dca != d0 + 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", dca - d0); end
        n_assert++; if (qa.size() != LEN2) begin n_fail++; $display("FAIL ignore_len: got %0d expected %0d", qa.size(), LEN2); end
        $display("[busy_send] %0d packet(s), %0d bytes", dca - d0, qa.size());
    endtask

    task automatic test_saturate();
        string exp;
        exp = with_trailer("P:9999");
        qs.delete();
        fields_s = 16'd12345;
        send_s = 1'b1; step(); send_s = 1'b0;
        for (int i = 0; i < 200; i++) begin step(); if (dcs != 0) break; end
        n_assert++; if (qs.size() != exp.len()) begin n_fail++; $display("FAIL sat_len: got %0d expected %0d", qs.size(), exp.len()); end
        for (int i = 0; i < exp.len() && i < qs.size(); i++) begin
            logic [7:0] e;
            e = exp[i];
            n_assert++; if (qs[i] !== e) begin n_fail++; $display("FAIL sat_byte%0d: got %02h expected %02h", i, qs[i], e); end
        end
        $display("[saturate] packet of %0d bytes", qs.size());
    endtask

    task automatic test_stall();
        string exp;
        int d0, nw, bad_wr, bad_wd;
        exp = with_trailer("P:0123:4095");
        d0 = dca;
        qa.delete(); ta.delete();
        fields_a = {12'd4095, 12'd123};
        send_a = 1'b1; step(); send_a = 1'b0;
        nw = 0;
        for (int i = 0; i < 20; i++) begin step(); if (wr_a) nw++; if (nw == 2) break; end
        full_a = 1'b1;
        bad_wr = 0; bad_wd = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (wr_a !== 1'b0) bad_wr++;
            if (wd_a !== 8'h30) bad_wd++;
        end
        full_a = 1'b0;
        n_assert++; if (bad_wr != 0) begin n_fail++; $display("FAIL stall_wr: %0d writes during stall, expected 0", bad_wr); end
        n_assert++; if (bad_wd != 0) begin n_fail++; $display("FAIL stall_wdata: %0d cycles not 30, expected 0 (last %02h)", bad_wd, wd_a); end
        for (int i = 0; i < 200; i++) begin step(); if (dca != d0) break; end
        n_assert++; if (qa.size() != exp.len()) begin n_fail++; $display("FAIL stall_len: got %0d expected %0d", qa.size(), exp.len()); end
        for (int i = 0; i < exp.len() && i < qa.size(); i++) begin
            logic [7:0] e;
            e = exp[i];
            n_assert++; if (qa[i] !== e) begin n_fail++; $display("FAIL stall_byte%0d: got %02h expected %02h", i, qa[i], e); end
        end
        $display("[stall] packet of %0d bytes after 10-cycle stall", qa.size());
    endtask

    task automatic test_tick_and_send();
        int d0;
        d0 = dct;
        for (int i = 0; i < 200; i++) begin step(); if (dct != d0) break; end
        repeat (TPER - 1 - 2 * LEN2) step();
        qt.delete();
        d0 = dct;
        send_t = 1'b1; step(); send_t = 1'b0;
        for (int i = 0; i < 200; i++) begin step(); if (dct != d0) break; end
        repeat (4) step();
        n_assert++; if (dct != d0 + 1) begin n_fail++; $display("FAIL coincide_done_count: got %0d expected 1", dct - d0); end
        n_assert++; if (qt.size() != LEN2) begin n_fail++; $display("FAIL coincide_len: got %0d expected %0d", qt.size(), LEN2); end
        $display("[tick_and_send] %0d packet(s), %0d bytes", dct - d0, qt.size());
    endtask

    task automatic test_snapshot();
        string exp;
        int d0, bad;
        exp = with_trailer("P:4001:0345");
        d0 = dct;
        for (int i = 0; i < 200; i++) begin step(); if (dct != d0) break; end
        repeat (3) step();
        qt.delete();
        d0 = dct;
        fields_t = {12'd345, 12'd4001};
        send_t = 1'b1; step(); send_t = 1'b0;
        repeat (4) step();
        fields_t = {12'd999, 12'd1};
        for (int i = 0; i < 200; i++) begin step(); if (dct != d0) break; end
        bad = 0;
        for (int k = 0; k < 5; k++) begin step(); if (busy_t !== 1'b0) bad++; end
        n_assert++; if (dct != d0 + 1) begin n_fail++; $display("FAIL snap_done_count: got %0d expected 1", dct - d0); end
        n_assert++; if (bad != 0) begin n_fail++; $display("FAIL snap_idle: busy %0d cycles after done, expected 0", bad); end
        n_assert++; if (qt.size() != exp.len()) begin n_fail++; $display("FAIL snap_len: got %0d expected %0d", qt.size(), exp.len()); end
        for (int i = 0; i < exp.len() && i < qt.size(); i++) begin
            logic [7:0] e;
            e = exp[i];
            n_assert++; if (qt[i] !== e) begin n_fail++; $display("FAIL snap_byte%0d: got %02h expected %02h", i, qt[i], e); end
        end
        $display("[snapshot] packet of %0d bytes", qt.size());
    endtask

    task automatic test_reset_mid();
        string exp;
        int d0, nw;
        exp = with_trailer("P:3000:0042");
        qa.delete(); ta.delete();
        fields_a = {12'd42, 12'd3000};
        d0 = dca;
        send_a = 1'b1; step(); send_a = 1'b0;
        nw = 0;
        for (int i = 0; i < 40; i++) begin step(); if (wr_a) nw++; if (nw == 5) break; end
        rst = 1'b1;
        step();
        n_assert++; if (wr_a !== 1'b0) begin n_fail++; $display("FAIL midrst_wr: got %b expected 0", wr_a); end
        n_assert++; if (wd_a !== 8'h00) begin n_fail++; $display("FAIL midrst_wdata: got %02h expected 00", wd_a); end
        n_assert++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy_a); end
        n_assert++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done_a); end
        repeat (2) step();
        rst = 1'b0;
        repeat (10) step();
        n_assert++; if (qa.size() != 5) begin n_fail++; $display("FAIL midrst_abort: got %0d bytes expected 5", qa.size()); end
        n_assert++; if (dca != d0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses expected 0", dca - d0); end
        qa.delete(); ta.delete();
        send_a = 1'b1; step(); send_a = 1'b0;
        for (int i = 0; i < 200; i++) begin step(); if (dca != d0) break; end
        n_assert++; if (qa.size() != exp.len()) begin n_fail++; $display("FAIL midrst_len: got %0d expected %0d", qa.size(), exp.len()); end
        for (int i = 0; i < exp.len() && i < qa.size(); i++) begin
            logic [7:0] e;
            e = exp[i];
            n_assert++; if (qa[i] !== e) begin n_fail++; $display("FAIL midrst_byte%0d: got %02h expected %02h", i, qa[i], e); end
        end
        $display("[reset_mid] restarted packet of %0d bytes", qa.size());
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_basic();
        test_busy_send_ignored();
        test_saturate();
        test_stall();
        test_tick_and_send();
        test_snapshot();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/coop_packet_tx.md
COOP_PACKET_TX -- requirements
Module: coop_packet_tx

Interface
REQ-001 Parameter FCLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter SEND_PERIOD_MS, default 50, periodic packet interval in ms; CYCLES = (FCLK_HZ/1000)*SEND_PERIOD_MS.
REQ-003 Parameter NUM_FIELDS, default 2, number of numeric fields per packet (1..8).
REQ-004 Parameter VAL_W, default 12, width of each unsigned field value (1..20).
REQ-005 Parameter DIGITS, default 4, decimal digits sent per field (1..6).
REQ-006 clk  input  1  system clock; one clock domain.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 fields  input  NUM_FIELDS*VAL_W  packed values; field 0 in the LSBs.
REQ-009 send_now  input  1  single-cycle request for an immediate packet.
REQ-010 tx_full  input  1  UART TX FIFO full; no write while high.
REQ-011 wr_uart  output  1  registered single-cycle write strobe to the UART.
REQ-012 w_data  output  8  registered byte, valid while wr_uart is high.
REQ-013 busy  output  1  high from packet start until pkt_done.
REQ-014 pkt_done  output  1  one-cycle pulse, asserted in the cycle after the final byte's wr_uart.

Function
REQ-015 Packet SHALL be 'P', then per field i = 0..NUM_FIELDS-1 one ':' plus DIGITS ASCII decimal digits (MSD first, zero-padded), then optional checksum (REQ-030), then "\r\n".
REQ-016 Internal period counter SHALL pulse tick once every CYCLES clocks, free-running from reset.
REQ-017 States: S_IDLE, S_SEND, S_GAP.
REQ-018 S_IDLE: on tick or send_now, SHALL snapshot fields into an internal register, clear byte index and checksum, set busy, and enter S_SEND next cycle.
REQ-019 Simultaneous tick and send_now SHALL start exactly one packet.
REQ-020 tick or send_now outside S_IDLE SHALL be ignored (not queued).
REQ-021 S_SEND: w_data SHALL present the byte for the current index; if tx_full is low, wr_uart SHALL be high in the next cycle and the state SHALL become S_GAP; if tx_full is high, the state SHALL hold with wr_uart low.
REQ-022 S_GAP: lasts exactly one cycle; SHALL advance the index and return to S_SEND, or, after the last byte, enter S_IDLE, clear busy and pulse pkt_done.
REQ-023 Digits SHALL derive only from the snapshot; changes on fields during a packet SHALL NOT affect that packet.
REQ-024 A field value above 10^DIGITS-1 SHALL saturate to all '9' digits.
REQ-025 Packet length SHALL be 3 + NUM_FIELDS*(1+DIGITS) bytes, plus 3 bytes when the checksum is enabled; the index counter SHALL be sized for the maximum length.

Reset
REQ-026 rst high SHALL force: state S_IDLE, wr_uart 0, w_data 8'h00, busy 0, pkt_done 0, index 0, checksum 0, snapshot 0, period counter 0.
REQ-027 rst mid-packet SHALL abort the packet with no further writes; the next packet SHALL start again from 'P'.
REQ-028 After rst deasserts, the first tick SHALL occur CYCLES clocks later.

Configuration
REQ-029 Macro COOP_TX_CSUM_EN selects the checksum feature.
REQ-030 Defined: after the last digit, SHALL send '*' plus two uppercase hex ASCII characters of the 8-bit XOR of all bytes from 'P' through the last digit; the XOR accumulates only on bytes actually written.
REQ-031 Undefined: no checksum bytes; "\r\n" follows the last digit directly; no checksum register.

Verification
REQ-032 Defaults, fields 123/4095, send_now pulse, tx_full 0 -> wr_uart bytes "P:0123:4095\r\n", one write every 2 cycles, then pkt_done pulse.
REQ-033 COOP_TX_CSUM_EN defined, same stimulus -> "P:0123:4095*58\r\n".
REQ-034 VAL_W=16, NUM_FIELDS=1, field 12345 -> "P:9999\r\n".
REQ-035 tx_full high 10 cycles during the third byte -> no wr_uart during the stall, w_data held at '0'; then the sequence resumes intact.
REQ-036 fields changed mid-packet, and tick during busy -> packet keeps snapshot values; no second packet starts.
REQ-037 rst pulse after the fifth byte -> all outputs at reset values; the next send_now produces a complete packet from 'P'.
